// File: rtl/bcd_occupancy_counter.sv
// bcd_occupancy_counter
// N-digit packed-BCD up/down occupancy counter with capacity limit,
// full/empty status, overflow/underflow pulses and saturate/wrap mode.
// Optional preset load is compiled in when BCD_OCC_LOAD_EN is defined;
// otherwise load/load_value are ignored and load_err is tied low.
module bcd_occupancy_counter #(
    parameter int DIGITS    = 2,
    parameter int MAX_COUNT = 99,
    parameter bit WRAP      = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inc,
    input  logic                dec,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_value,
    output logic [4*DIGITS-1:0] count,
    output logic                full,
    output logic                empty,
    output logic                overflow,
    output logic                underflow,
    output logic                load_err
);

    localparam int W = 4 * DIGITS;

    // Elaboration-time binary to BCD conversion of the capacity limit.
    function automatic logic [W-1:0] to_bcd(input int unsigned value);
        logic [W-1:0] r;
        int unsigned  v;
        r = '0;
        v = value;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    localparam logic [W-1:0] MAX_BCD = to_bcd(MAX_COUNT);

    logic [W-1:0] count_q, count_d;
    logic [W-1:0] count_inc, count_dec;
    logic         full_q, empty_q;
    logic         ovf_q, ovf_d;
    logic         unf_q, unf_d;
    logic         at_max, at_zero;

    assign at_max  = (count_q == MAX_BCD);
    assign at_zero = (count_q == '0);

    // Digit-serial BCD increment: 9 rolls to 0 and carries upward.
    always_comb begin
        logic       carry;
        logic [3:0] nib;
        carry     = 1'b1;
        count_inc = count_q;
        for (int i = 0; i < DIGITS; i++) begin
            nib = count_q[4*i +: 4];
            if (carry) begin
                if (nib == 4'd9) begin
                    count_inc[4*i +: 4] = 4'd0;
                end else begin
                    count_inc[4*i +: 4] = nib + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    // Digit-serial BCD decrement: 0 rolls to 9 and borrows upward.
    always_comb begin
        logic       borrow;
        logic [3:0] nib;
        borrow    = 1'b1;
        count_dec = count_q;
        for (int i = 0; i < DIGITS; i++) begin
            nib = count_q[4*i +: 4];
            if (borrow) begin
                if (nib == 4'd0) begin
                    count_dec[4*i +: 4] = 4'd9;
                end else begin
                    count_dec[4*i +: 4] = nib - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    end

`ifdef BCD_OCC_LOAD_EN
    logic load_ok;
    logic lerr_q, lerr_d;

    // Preset is legal only if every nibble is a BCD digit and the value fits
    // the capacity; with valid digits a packed-BCD compare is a numeric one.
    always_comb begin
        load_ok = (load_value <= MAX_BCD);
        for (int i = 0; i < DIGITS; i++) begin
            if (load_value[4*i +: 4] > 4'd9) begin
                load_ok = 1'b0;
            end
        end
    end
`else
    logic unused_load;
    assign unused_load = ^{load, load_value};
`endif

    // Next count and event pulses; load (when present) beats the strobes.
    always_comb begin
        count_d = count_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
`ifdef BCD_OCC_LOAD_EN
        lerr_d  = 1'b0;
        if (load) begin
            if (load_ok) begin
                count_d = load_value;
            end else begin
                lerr_d = 1'b1;
            end
        end else
`endif
        if (inc && !dec) begin
            if (at_max) begin
                ovf_d = 1'b1;
                if (WRAP) begin
                    count_d = '0;
                end
            end else begin
                count_d = count_inc;
            end
        end else if (dec && !inc) begin
            if (at_zero) begin
                unf_d = 1'b1;
                if (WRAP) begin
                    count_d = MAX_BCD;
                end
            end else begin
                count_d = count_dec;
            end
        end
    end

    // State and status registers; full/empty come from the next count so
    // they stay coherent with count.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            full_q  <= (count_d == MAX_BCD);
            empty_q <= (count_d == '0);
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

`ifdef BCD_OCC_LOAD_EN
    // Preset-rejection pulse register.
    always_ff @(posedge clk) begin
        if (reset) begin
            lerr_q <= 1'b0;
        end else begin
            lerr_q <= lerr_d;
        end
    end

    assign load_err = lerr_q;
`else
    assign load_err = 1'b0;
`endif

    assign count     = count_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_bcd_occupancy_counter.sv
// Testbench for bcd_occupancy_counter: three instances (99 saturate,
// 25 saturate, 25 wrap) share stimulus; a behavioural integer model pushes
// expected outputs into a queue that is popped after each clock edge.
module tb_bcd_occupancy_counter;

`ifdef BCD_OCC_LOAD_EN
    localparam bit LOAD_EN = 1'b1;
`else
    localparam bit LOAD_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic inc = 1'b0;
    logic dec = 1'b0;
    logic load = 1'b0;
    logic [7:0] load_value = 8'h00;

    logic [2:0][7:0] cnt_w;
    logic [2:0] full_w, empty_w, ovf_w, unf_w, lerr_w;

    always #5 clk = ~clk;

    bcd_occupancy_counter #(.DIGITS(2), .MAX_COUNT(99), .WRAP(1'b0)) u_d99 (
        .clk(clk), .reset(reset), .inc(inc), .dec(dec), .load(load),
        .load_value(load_value), .count(cnt_w[0]), .full(full_w[0]),
        .empty(empty_w[0]), .overflow(ovf_w[0]), .underflow(unf_w[0]),
        .load_err(lerr_w[0]));

    bcd_occupancy_counter #(.DIGITS(2), .MAX_COUNT(25), .WRAP(1'b0)) u_sat25 (
        .clk(clk), .reset(reset), .inc(inc), .dec(dec), .load(load),
        .load_value(load_value), .count(cnt_w[1]), .full(full_w[1]),
        .empty(empty_w[1]), .overflow(ovf_w[1]), .underflow(unf_w[1]),
        .load_err(lerr_w[1]));

    bcd_occupancy_counter #(.DIGITS(2), .MAX_COUNT(25), .WRAP(1'b1)) u_wrap25 (
        .clk(clk), .reset(reset), .inc(inc), .dec(dec), .load(load),
        .load_value(load_value), .count(cnt_w[2]), .full(full_w[2]),
        .empty(empty_w[2]), .overflow(ovf_w[2]), .underflow(unf_w[2]),
        .load_err(lerr_w[2]));

    typedef struct packed {
        logic [2:0][7:0] count;
        logic [2:0]      full;
        logic [2:0]      empty;
        logic [2:0]      ovf;
        logic [2:0]      unf;
        logic [2:0]      lerr;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    int m_cnt[3]  = '{0, 0, 0};
    int m_max[3]  = '{99, 25, 25};
    bit m_wrap[3] = '{1'b0, 1'b0, 1'b1};

    function automatic logic [7:0] bcd8(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic cmp(input string tag, input int idx, input logic [7:0] obs,
                       input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s[%0d] at %0t: got %h expected %h", tag, idx, $time, obs, exp);
        end
    endtask

    task automatic check();
        exp_t e;
        tests++;
        assert (sb.size() != 0) else begin
            fails++;
            $error("FAIL scoreboard_empty: got size %0d expected >0", sb.size());
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            for (int i = 0; i < 3; i++) begin
                cmp("count", i, cnt_w[i], e.count[i]);
                cmp("full", i, {7'd0, full_w[i]}, {7'd0, e.full[i]});
                cmp("empty", i, {7'd0, empty_w[i]}, {7'd0, e.empty[i]});
                cmp("overflow", i, {7'd0, ovf_w[i]}, {7'd0, e.ovf[i]});
                cmp("underflow", i, {7'd0, unf_w[i]}, {7'd0, e.unf[i]});
                cmp("load_err", i, {7'd0, lerr_w[i]}, {7'd0, e.lerr[i]});
            end
        end
    endtask

    task automatic step(input logic i_inc, input logic i_dec, input logic i_ld,
                        input logic [7:0] i_lv, input logic i_rst);
        exp_t e;
        int   hi, lo, val;
        @(negedge clk);
        inc        = i_inc;
        dec        = i_dec;
        load       = i_ld;
        load_value = i_lv;
        reset      = i_rst;
        e = '0;
        hi  = int'(i_lv[7:4]);
        lo  = int'(i_lv[3:0]);
        val = hi * 10 + lo;
        for (int k = 0; k < 3; k++) begin
            if (i_rst) begin
                m_cnt[k] = 0;
            end else if (LOAD_EN && i_ld) begin
                if (hi <= 9 && lo <= 9 && val <= m_max[k]) m_cnt[k] = val;
                else e.lerr[k] = 1'b1;
            end else if (i_inc && !i_dec) begin
                if (m_cnt[k] == m_max[k]) begin
                    e.ovf[k] = 1'b1;
                    if (m_wrap[k]) m_cnt[k] = 0;
                end else begin
                    m_cnt[k] = m_cnt[k] + 1;
                end
            end else if (i_dec && !i_inc) begin
                if (m_cnt[k] == 0) begin
                    e.unf[k] = 1'b1;
                    if (m_wrap[k]) m_cnt[k] = m_max[k];
                end else begin
                    m_cnt[k] = m_cnt[k] - 1;
                end
            end
            e.count[k] = bcd8(m_cnt[k]);
            e.full[k]  = (m_cnt[k] == m_max[k]);
            e.empty[k] = (m_cnt[k] == 0);
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        check();
    endtask

    task automatic incs(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        // Reset
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        // Count up to 09, then digit carry/borrow across the 09/10 boundary
        incs(9);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        // Up to 12, then up to the 25 limit
        incs(3);
        incs(13);
        // Increment at limit: saturate holds, wrap goes to 0, 99 counts on
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        // Simultaneous inc and dec at the limit: no change, no pulse
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        // Reset beats a concurrent increment
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        // Decrement at zero: saturate holds, wrap goes to 25
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        // Presets: bad nibble, over capacity, valid with concurrent inc
        step(1'b0, 1'b0, 1'b1, 8'h1A, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h30, 1'b0);
        step(1'b1, 1'b0, 1'b1, 8'h20, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'h25, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        // Back-to-back decrements through a digit borrow
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) == 0),
                 {4'($urandom_range(0, 3)), 4'($urandom_range(0, 11))},
                 ($urandom_range(0, 59) == 0));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
